// File: rtl/md_sequencer_pkg.sv
// md_pkg: shared definitions for the multiply/divide sequencer.
//   - md_op codes presented by the EX stage
//   - sequencer state encoding
//   - small op-class helper functions
package md_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MTLO  = 4'd6;
  localparam logic [3:0] MD_MFHI  = 4'd7;
  localparam logic [3:0] MD_MFLO  = 4'd8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_t;

  // Multi-cycle ops: these occupy the unit and drive busy.
  function automatic logic is_long_op(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_mult_op(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

endpackage

// File: rtl/md_sequencer_if.sv
// md_sequencer_if: EX-stage <-> multiply/divide sequencer bundle.
//   op_e, rs_e, rt_e : operation and forwarded operands of the E instruction
//   int_clr          : exception flush of the E instruction
//   md_in_d          : D-stage instruction is HI/LO-class
//   busy, stall_md   : unit occupied / stall request to the hazard unit
//   hi, lo, mf_out   : architectural HI/LO and MFHI/MFLO result
// master = pipeline side, slave = sequencer.
interface md_sequencer_if;
  import md_pkg::*;

  logic [3:0]  op_e;
  logic [31:0] rs_e;
  logic [31:0] rt_e;
  logic        int_clr;
  logic        md_in_d;
  logic        busy;
  logic        stall_md;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mf_out;

  modport master (
    output op_e, rs_e, rt_e, int_clr, md_in_d,
    input  busy, stall_md, hi, lo, mf_out
  );

  modport slave (
    input  op_e, rs_e, rt_e, int_clr, md_in_d,
    output busy, stall_md, hi, lo, mf_out
  );

endinterface

// File: rtl/md_sequencer_calc.sv
// md_calc: combinational multiply/divide datapath.
//   i_op            : md_op code
//   i_a, i_b        : rs / rt operands
//   o_res_hi/lo     : HI/LO result for MULT/MULTU/DIV/DIVU (0 otherwise)
//   o_div0          : divide op with a zero divisor
module md_calc
  import md_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_res_hi,
  output logic [31:0] o_res_lo,
  output logic        o_div0
);

  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic        w_signed_div;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_b_safe;
  logic        w_b_zero;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_q;
  logic [31:0] w_r;

  // Low 64 bits of the product of sign-extended operands is the signed product.
  assign w_prod_s = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
  assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

  // Signed divide runs on magnitudes, then the signs are restored:
  // quotient negative when operand signs differ, remainder takes the
  // dividend's sign. 0x80000000 / -1 falls out as q=0x80000000, r=0.
  assign w_signed_div = (i_op == MD_DIV);
  assign w_a_neg      = w_signed_div & i_a[31];
  assign w_b_neg      = w_signed_div & i_b[31];
  assign w_a_mag      = w_a_neg ? (~i_a + 32'd1) : i_a;
  assign w_b_mag      = w_b_neg ? (~i_b + 32'd1) : i_b;
  assign w_b_zero     = (i_b == 32'd0);
  // Keep the divider defined on a zero divisor; the result is discarded anyway.
  assign w_b_safe     = w_b_zero ? 32'd1 : w_b_mag;
  assign w_q_mag      = w_a_mag / w_b_safe;
  assign w_r_mag      = w_a_mag % w_b_safe;
  assign w_q          = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
  assign w_r          = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;

  always_comb begin
    o_res_hi = 32'd0;
    o_res_lo = 32'd0;
    o_div0   = 1'b0;
    case (i_op)
      MD_MULT:  {o_res_hi, o_res_lo} = w_prod_s;
      MD_MULTU: {o_res_hi, o_res_lo} = w_prod_u;
      MD_DIV, MD_DIVU: begin
        o_res_hi = w_r;
        o_res_lo = w_q;
        o_div0   = w_b_zero;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_sequencer.sv
// md_sequencer: EX-stage HI/LO unit sequencer.
//   i_clk   : system clock, rising edge
//   i_reset : synchronous active-high reset
//   md_bus  : md_sequencer_if.slave (ops/operands in; busy, stall, HI/LO out)
// Result is computed at launch and parked in pending registers; HI/LO are
// updated on the edge that ends the last busy cycle.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | unit free; accepts MULT/DIV launch, MTHI/MTLO write directly
//   ST_RUN  | MULT/DIV in flight; counter counts N..1, commit on 1
module md_sequencer
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic          i_clk,
  input  logic          i_reset,
  md_sequencer_if.slave md_bus
);

  localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);

  md_state_t        r_state;
  md_state_t        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [31:0]      r_pend_hi;
  logic [31:0]      r_pend_lo;
  logic             r_pend_div0;

  logic             w_busy;
  logic             w_go;
  logic             w_go_md;
  logic             w_commit;
  logic [31:0]      w_res_hi;
  logic [31:0]      w_res_lo;
  logic             w_div0;

  md_calc u_calc (
    .i_op     (md_bus.op_e),
    .i_a      (md_bus.rs_e),
    .i_b      (md_bus.rt_e),
    .o_res_hi (w_res_hi),
    .o_res_lo (w_res_lo),
    .o_div0   (w_div0)
  );

  assign w_busy  = (r_state == ST_RUN);
  assign w_go    = (md_bus.op_e != MD_NONE) & ~md_bus.int_clr & ~w_busy;
  assign w_go_md = w_go & is_long_op(md_bus.op_e);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_commit    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_go_md) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = is_mult_op(md_bus.op_e) ? MULT_N : DIV_N;
        end
      end
      ST_RUN: begin
        // Down-counter saturates at 0; terminal count 1 ends the run.
        if (r_cnt != '0) w_cnt_nxt = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = ST_IDLE;
          w_commit    = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // MTHI/MTLO need w_go (so ~busy) and commit needs ST_RUN, so the two
  // HI/LO write sources can never collide.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_hi        <= 32'd0;
      r_lo        <= 32'd0;
      r_pend_hi   <= 32'd0;
      r_pend_lo   <= 32'd0;
      r_pend_div0 <= 1'b0;
    end else begin
      if (w_go_md) begin
        r_pend_hi   <= w_res_hi;
        r_pend_lo   <= w_res_lo;
        r_pend_div0 <= w_div0;
      end
      if (w_go && (md_bus.op_e == MD_MTHI)) r_hi <= md_bus.rs_e;
      if (w_go && (md_bus.op_e == MD_MTLO)) r_lo <= md_bus.rs_e;
      if (w_commit && !r_pend_div0) begin
        r_hi <= r_pend_hi;
        r_lo <= r_pend_lo;
      end
    end
  end

  assign md_bus.busy     = w_busy;
  assign md_bus.stall_md = md_bus.md_in_d & (w_busy | w_go_md);
  assign md_bus.hi       = r_hi;
  assign md_bus.lo       = r_lo;

  always_comb begin
    md_bus.mf_out = 32'd0;
    if (md_bus.op_e == MD_MFHI) md_bus.mf_out = r_hi;
    if (md_bus.op_e == MD_MFLO) md_bus.mf_out = r_lo;
  end

endmodule

// File: tb/tb_md_sequencer.sv
module tb_md_sequencer;
  import md_pkg::*;

  logic clk = 1'b0;
  logic reset;

  md_sequencer_if md_bus ();

  md_sequencer #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10),
    .CNT_W       (4)
  ) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .md_bus  (md_bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
    md_bus.op_e = op;
    md_bus.rs_e = rs;
    md_bus.rt_e = rt;
  endtask

  // Launch in cycle t, return positioned in cycle t+n+1.
  task automatic run_op(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        input int n);
    drive(op, rs, rt);
    tick();
    md_bus.op_e = MD_NONE;
    repeat (n) tick();
  endtask

  initial begin
    reset          = 1'b1;
    md_bus.int_clr = 1'b0;
    md_bus.md_in_d = 1'b0;
    drive(MD_NONE, 32'd0, 32'd0);
    repeat (3) tick();
    reset = 1'b0;
    #1;
    check("rst_busy",  32'(md_bus.busy), 32'd0);
    check("rst_stall", 32'(md_bus.stall_md), 32'd0);
    check("rst_hi",    md_bus.hi, 32'd0);
    check("rst_lo",    md_bus.lo, 32'd0);
    check("rst_mfout", md_bus.mf_out, 32'd0);
    tick();

    // MULT -2 * 3, busy t+1..t+5, result at t+6
    drive(MD_MULT, 32'hFFFF_FFFE, 32'd3);
    #1;
    check("mult_t_busy",  32'(md_bus.busy), 32'd0);
    check("mult_t_stall", 32'(md_bus.stall_md), 32'd0);
    tick();
    md_bus.op_e = MD_NONE;
    for (int k = 1; k <= 5; k++) begin
      #1;
      check($sformatf("mult_busy_%0d", k), 32'(md_bus.busy), 32'd1);
      if (k == 5) check("mult_hi_precommit", md_bus.hi, 32'd0);
      tick();
    end
    #1;
    check("mult_done_busy", 32'(md_bus.busy), 32'd0);
    check("mult_hi", md_bus.hi, 32'hFFFF_FFFF);
    check("mult_lo", md_bus.lo, 32'hFFFF_FFFA);

    // DIVU 100/7 with MFLO waiting in D
    drive(MD_DIVU, 32'd100, 32'd7);
    md_bus.md_in_d = 1'b1;
    #1;
    check("divu_t_stall", 32'(md_bus.stall_md), 32'd1);
    check("divu_t_busy",  32'(md_bus.busy), 32'd0);
    tick();
    md_bus.op_e = MD_NONE;
    for (int k = 1; k <= 10; k++) begin
      #1;
      check($sformatf("divu_stall_%0d", k), 32'(md_bus.stall_md), 32'd1);
      tick();
    end
    md_bus.op_e = MD_MFLO;
    #1;
    check("divu_stall_end", 32'(md_bus.stall_md), 32'd0);
    check("divu_busy_end",  32'(md_bus.busy), 32'd0);
    check("divu_mflo",      md_bus.mf_out, 32'd14);
    md_bus.op_e = MD_MFHI;
    #1;
    check("divu_mfhi", md_bus.mf_out, 32'd2);
    md_bus.op_e    = MD_NONE;
    md_bus.md_in_d = 1'b0;
    #1;
    check("mfout_idle", md_bus.mf_out, 32'd0);
    tick();

    // Signed divide sign fix-up and overflow
    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 10);
    #1;
    check("div_neg_busy", 32'(md_bus.busy), 32'd0);
    check("div_neg_lo", md_bus.lo, 32'hFFFF_FFFD);
    check("div_neg_hi", md_bus.hi, 32'hFFFF_FFFF);
    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10);
    #1;
    check("div_ovf_lo", md_bus.lo, 32'h8000_0000);
    check("div_ovf_hi", md_bus.hi, 32'd0);

    // MTHI flushed, then retried
    drive(MD_MTHI, 32'h1234_5678, 32'd0);
    md_bus.int_clr = 1'b1;
    tick();
    md_bus.int_clr = 1'b0;
    #1;
    check("mthi_flushed_hi", md_bus.hi, 32'd0);
    check("mthi_flushed_busy", 32'(md_bus.busy), 32'd0);
    tick();
    md_bus.op_e = MD_NONE;
    #1;
    check("mthi_hi",   md_bus.hi, 32'h1234_5678);
    check("mthi_busy", 32'(md_bus.busy), 32'd0);

    // MTLO, then divide by zero with a late flush and an illegal op while busy
    drive(MD_MTLO, 32'h0000_00AA, 32'd0);
    tick();
    md_bus.op_e = MD_NONE;
    #1;
    check("mtlo_lo", md_bus.lo, 32'h0000_00AA);
    drive(MD_DIV, 32'd5, 32'd0);
    tick();
    for (int k = 1; k <= 10; k++) begin
      md_bus.int_clr = (k == 3);
      if (k == 5) drive(MD_MTLO, 32'h0000_0055, 32'd0);
      else md_bus.op_e = MD_NONE;
      #1;
      check($sformatf("div0_busy_%0d", k), 32'(md_bus.busy), 32'd1);
      tick();
    end
    md_bus.int_clr = 1'b0;
    md_bus.op_e    = MD_NONE;
    #1;
    check("div0_busy_end", 32'(md_bus.busy), 32'd0);
    check("div0_lo", md_bus.lo, 32'h0000_00AA);
    check("div0_hi", md_bus.hi, 32'h1234_5678);

    // MULTU abandoned by reset in busy cycle 2
    drive(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick();
    md_bus.op_e = MD_NONE;
    #1;
    check("multu_busy_1", 32'(md_bus.busy), 32'd1);
    tick();
    reset = 1'b1;
    #1;
    check("multu_busy_2", 32'(md_bus.busy), 32'd1);
    tick();
    reset = 1'b0;
    #1;
    check("rst_mid_busy", 32'(md_bus.busy), 32'd0);
    check("rst_mid_hi", md_bus.hi, 32'd0);
    check("rst_mid_lo", md_bus.lo, 32'd0);
    repeat (6) tick();
    #1;
    check("rst_late_busy", 32'(md_bus.busy), 32'd0);
    check("rst_late_hi", md_bus.hi, 32'd0);
    check("rst_late_lo", md_bus.lo, 32'd0);

    // Unit usable after the abandoned run
    run_op(MD_MULT, 32'd7, 32'd6, 5);
    #1;
    check("post_rst_lo", md_bus.lo, 32'd42);
    check("post_rst_hi", md_bus.hi, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/md_sequencer.md
Name: md_sequencer

Overview:
- Sequencer for the multiply/divide resource used in the EX stage.
- Accepts one HI/LO-class operation per cycle from E and holds the HI/LO registers.
- Models fixed multi-cycle latency for MULT/DIV, drives BUSY, and raises the D-stage stall request for the hazard unit.
- Honours the exception flush (int_clr) so a flushed instruction never changes HI/LO.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (>=1)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (>=1)
- CNT_W, 4, counter width; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- op_e  in  4  md_op code of the instruction in E (MD_NONE when not an HI/LO instruction)
- rs_e  in  32  forwarded rs operand
- rt_e  in  32  forwarded rt operand
- int_clr  in  1  exception flush: the E instruction is cancelled this cycle
- md_in_d  in  1  instruction in D is any HI/LO-class op
- busy  out  1  MULT/DIV in flight
- stall_md  out  1  stall request to the hazard unit
- hi  out  32  current HI
- lo  out  32  current LO
- mf_out  out  32  MFHI/MFLO result, forwarded to M as XALUOUT

Behaviour:
- Reset: busy=0, hi=0, lo=0, counter=0, pending regs=0, state IDLE. Reset mid-operation abandons the operation with no commit.
- Launch qualifier: go = (op_e != MD_NONE) & ~int_clr & ~busy.
- Two states:
  - IDLE -> RUN on go with MULT/MULTU/DIV/DIVU.
  - RUN -> IDLE when the counter reaches 1.
- Latency:
  - Launch is in cycle t. The result is computed combinationally from rs_e/rt_e and latched into pend_hi/pend_lo at the t edge.
  - The counter is loaded with N (MULT_CYCLES or DIV_CYCLES).
  - busy is high in cycles t+1..t+N.
  - HI/LO are written at the edge ending cycle t+N. New values and busy=0 are visible in t+N+1.
- Arithmetic:
  - MULT: {hi,lo} = signed 32x32 -> 64.
  - MULTU: {hi,lo} = unsigned 32x32 -> 64.
  - DIV: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIVU: lo = unsigned quotient; hi = unsigned remainder.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): lo=0x80000000, hi=0.
  - Divide by zero: busy runs DIV_CYCLES normally; HI/LO are left unchanged at commit.
- MTHI/MTLO (when go): write rs_e to hi/lo at the t edge. Single cycle, no busy.
- MFHI/MFLO: mf_out = hi or lo combinationally (registered values), valid regardless of busy.
- When op_e is not MFHI/MFLO, mf_out = 0.
- op_e != MD_NONE while busy: ignored, no state change. Upstream stall guarantees this never happens in legal flow.
- int_clr while busy: no effect. The in-flight op is already committed architecturally and completes.
- int_clr in the launch cycle: launch suppressed; MTHI/MTLO write suppressed.
- stall_md = md_in_d & (busy | go_md), where go_md = go with a MULT/MULTU/DIV/DIVU op.
- MTHI/MTLO in E do not stall D.
- Commit edge (busy still high in cycle t+N): stall_md is still asserted. A D-stage MFHI enters E in t+N+1 and reads the committed value.
- Counter never wraps: it decrements only in RUN and stops at 0.

Decomposition:
- Package md_pkg holds:
  - md_op localparams: MD_NONE=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MTHI=5, MD_MTLO=6, MD_MFHI=7, MD_MFLO=8.
  - State encodings IDLE/RUN.
- One sub-module, md_calc: pure combinational. Takes op, a, b and produces res_hi, res_lo, div0, including the signed-divide sign fix-ups.
- md_sequencer holds the FSM, counter, pending and HI/LO registers, and the stall logic.

Test Plan:
- MULT rs=0xFFFFFFFE (-2), rt=3 at t, md_in_d=0 -> busy high t+1..t+5; hi=0xFFFFFFFF, lo=0xFFFFFFFA visible at t+6.
- DIVU rs=100, rt=7, with MFLO held in D -> stall_md high t..t+10, low at t+11; MFLO in E then gives mf_out=14; hi=2.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Then DIV 0x80000000 by 0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI rs=0x12345678 with int_clr=1 -> hi unchanged. Next cycle the same op with int_clr=0 -> hi=0x12345678 the next cycle, busy stays 0.
- DIV by rt=0 after MTLO 0xAA -> busy for 10 cycles, lo stays 0xAA. int_clr asserted at busy cycle 3 -> run still completes.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF, reset asserted at busy cycle 2 -> next cycle busy=0, hi=lo=0, no later commit.
